// File: rtl/eth_rx_pkg.sv
// Shared types and constants for the Ethernet receive frame ring.
package eth_rx_pkg;

  // Receive FSM states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECV    = 2'd1,
    DISCARD = 2'd2
  } rx_state_e;

  // Reason a frame is being discarded; DROP_NONE means "not counted"
  typedef enum logic [1:0] {
    DROP_NONE     = 2'd0,
    DROP_FULL     = 2'd1,
    DROP_OVERSIZE = 2'd2
  } drop_cause_e;

  localparam logic [47:0] BCAST_MAC         = 48'hFFFF_FFFF_FFFF;
  localparam logic [23:0] IPV4_MCAST_PREFIX = 24'h01005E;

  // 6-bit multicast hash: XOR of the low six bits of each destination byte
  function automatic logic [5:0] mac_hash(input logic [47:0] mac);
    logic [5:0] h;
    h = 6'd0;
    for (int i = 0; i < 6; i++) begin
      h = h ^ mac[8*i +: 6];
    end
    return h;
  endfunction

endpackage

// File: rtl/eth_rx_ring_ram.sv
// Frame buffer storage: 64-bit words, byte-enable write port, registered read port.
module eth_rx_ring_ram #(
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [7:0]    be,
  input  logic [AW-1:0] wr_addr,
  input  logic [63:0]   wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [63:0]   rd_data
);

  logic [63:0] mem_r [2**AW];

  // Byte-lane write; storage itself carries no reset
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 8; i++) begin
        if (be[i]) begin
          mem_r[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  // One-cycle read; output holds while rd_en is low
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= 64'd0;
    end else if (rd_en) begin
      rd_data <= mem_r[rd_addr];
    end else begin
      rd_data <= rd_data;
    end
  end

endmodule

// File: rtl/eth_rx_ring.sv
// Ethernet receive frame ring: address filter, NBUF-buffer ring, length table,
// runt/oversize/error/full-ring discard and saturating drop counter.
// Optional build macro ETH_RX_MCAST_HASH_EN replaces the 01:00:5E prefix
// acceptance rule with a 64-entry multicast hash lookup.
module eth_rx_ring
  import eth_rx_pkg::*;
#(
  parameter int  NBUF      = 8,
  parameter int  BUF_BYTES = 2048,
  parameter int  MIN_LEN   = 14,
  localparam int PW        = $clog2(NBUF),
  localparam int LW        = $clog2(BUF_BYTES) + 1
) (
  input  logic               msoc_clk,
  input  logic               rst_int,
  input  logic [7:0]         rx_axis_tdata,
  input  logic               rx_axis_tvalid,
  input  logic               rx_axis_tlast,
  input  logic               rx_axis_tuser,
  input  logic [47:0]        mac_address,
  input  logic               promiscuous,
  input  logic               irq_en,
  input  logic [63:0]        mcast_hash,
  input  logic               rd_en,
  input  logic [PW+LW-5:0]   rd_addr,
  output logic [63:0]        rd_data,
  input  logic [PW-1:0]      len_sel,
  output logic [LW-1:0]      len_data,
  input  logic               release_we,
  input  logic [PW-1:0]      release_ptr,
  output logic [PW-1:0]      firstbuf,
  output logic [PW-1:0]      nextbuf,
  output logic               avail,
  output logic               full,
  output logic [15:0]        drop_count,
  output logic               eth_irq
);

  localparam int            AW        = PW + LW - 4;
  localparam logic [LW-1:0] MIN_LEN_L = LW'(MIN_LEN);
  localparam logic [LW-1:0] LAST_IDX  = LW'(BUF_BYTES - 1);
  localparam logic [LW-1:0] HDR_BYTES = LW'(6);

  rx_state_e     state_r;
  drop_cause_e   cause_r;
  logic [LW-1:0] count_r;
  logic [47:0]   dest_mac_r;
  logic [PW-1:0] firstbuf_r;
  logic [PW-1:0] nextbuf_r;
  logic [15:0]   drop_count_r;
  logic          eth_irq_r;
  logic [LW-1:0] len_table_r [NBUF];

  logic [PW-1:0] next_ptr_s;
  logic          full_s;
  logic          avail_s;
  logic [LW-1:0] cur_count_s;
  logic [LW-1:0] frame_len_s;
  logic          take_byte_s;
  logic          group_ok_s;
  logic          addr_match_s;
  logic          commit_s;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Ring occupancy flags derived from the registered pointers
  always_comb begin
    next_ptr_s = nextbuf_r + PW'(1);
    full_s     = (next_ptr_s == firstbuf_r);
    avail_s    = (nextbuf_r != firstbuf_r);
  end

  // Byte acceptance: frame start in IDLE counts as byte 0 of a new frame
  always_comb begin
    cur_count_s = (state_r == IDLE) ? {LW{1'b0}} : count_r;
    frame_len_s = cur_count_s + LW'(1);
    take_byte_s = 1'b0;
    if (rx_axis_tvalid) begin
      case (state_r)
        IDLE:    take_byte_s = !full_s;
        RECV:    take_byte_s = 1'b1;
        default: take_byte_s = 1'b0;
      endcase
    end else begin
      take_byte_s = 1'b0;
    end
  end

  // Destination filter and commit decision at end of frame
  always_comb begin
`ifdef ETH_RX_MCAST_HASH_EN
    group_ok_s = dest_mac_r[40] && (dest_mac_r != BCAST_MAC) &&
                 mcast_hash[mac_hash(dest_mac_r)];
`else
    group_ok_s = (dest_mac_r[47:24] == IPV4_MCAST_PREFIX);
`endif
    addr_match_s = promiscuous || (dest_mac_r == BCAST_MAC) ||
                   (dest_mac_r == mac_address) || group_ok_s;
    if (take_byte_s && rx_axis_tlast && !rx_axis_tuser &&
        (cur_count_s >= HDR_BYTES) && (frame_len_s >= MIN_LEN_L) && addr_match_s) begin
      commit_s = 1'b1;
    end else begin
      commit_s = 1'b0;
    end
  end

`ifndef ETH_RX_MCAST_HASH_EN
  logic unused_mcast_hash;
  assign unused_mcast_hash = ^mcast_hash;
`endif

  // Receive FSM, ring pointers, drop counter and interrupt
  always_ff @(posedge msoc_clk) begin
    if (rst_int) begin
      state_r      <= IDLE;
      cause_r      <= DROP_NONE;
      count_r      <= {LW{1'b0}};
      dest_mac_r   <= 48'd0;
      firstbuf_r   <= {PW{1'b0}};
      nextbuf_r    <= {PW{1'b0}};
      drop_count_r <= 16'd0;
      eth_irq_r    <= 1'b0;
    end else begin
      eth_irq_r <= avail_s & irq_en;
      if (release_we) begin
        firstbuf_r <= release_ptr;
      end
      if (commit_s) begin
        nextbuf_r <= next_ptr_s;
      end
      if (take_byte_s) begin
        if (cur_count_s < HDR_BYTES) begin
          dest_mac_r <= {dest_mac_r[39:0], rx_axis_tdata};
        end
        if (rx_axis_tlast) begin
          state_r <= IDLE;
        end else if (cur_count_s == LAST_IDX) begin
          state_r <= DISCARD;
          cause_r <= DROP_OVERSIZE;
        end else begin
          state_r <= RECV;
          count_r <= cur_count_s + LW'(1);
        end
      end else if (rx_axis_tvalid) begin
        case (state_r)
          IDLE: begin
            // ring full at frame start
            if (rx_axis_tlast) begin
              drop_count_r <= sat_inc16(drop_count_r);
            end else begin
              state_r <= DISCARD;
              cause_r <= DROP_FULL;
            end
          end
          DISCARD: begin
            if (rx_axis_tlast) begin
              if (cause_r != DROP_NONE) begin
                drop_count_r <= sat_inc16(drop_count_r);
              end
              state_r <= IDLE;
              cause_r <= DROP_NONE;
            end
          end
          default: state_r <= IDLE;
        endcase
      end
    end
  end

  // Length table: written on commit, intentionally not reset
  always_ff @(posedge msoc_clk) begin
    if (commit_s) begin
      len_table_r[nextbuf_r] <= frame_len_s;
    end
  end

  eth_rx_ring_ram #(.AW(AW)) u_ram (
    .clk     (msoc_clk),
    .rst     (rst_int),
    .we      (take_byte_s),
    .be      (8'b1 << cur_count_s[2:0]),
    .wr_addr ({nextbuf_r, cur_count_s[LW-2:3]}),
    .wr_data ({8{rx_axis_tdata}}),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign len_data   = len_table_r[len_sel];
  assign firstbuf   = firstbuf_r;
  assign nextbuf    = nextbuf_r;
  assign avail      = avail_s;
  assign full       = full_s;
  assign drop_count = drop_count_r;
  assign eth_irq    = eth_irq_r;

endmodule

// File: doc/eth_rx_ring.md
Name: eth_rx_ring

Overview:
Parametrised receive frame ring for the Ethernet framing path. It takes the MAC's byte-wide AXI-stream receive output, already in the msoc_clk domain. It applies destination-address filtering and stores accepted frames into a ring of NBUF equal-size buffers, together with a per-buffer length table. The CPU reads frames through a 64-bit word port and frees buffers by writing a release pointer. Compared with the fixed 8-buffer receiver, it adds:
- configurable buffer count and size
- oversize, runt and error-frame discard
- full-ring drop counting

Parameters:
NBUF, 8, number of frame buffers; power of two, 2..16
BUF_BYTES, 2048, bytes per buffer; power of two, 256..4096
MIN_LEN, 14, shortest accepted frame in bytes; shorter frames are runts
PW, $clog2(NBUF), ring pointer width (derived, not overridable)
LW, $clog2(BUF_BYTES)+1, frame length width (derived)

Ports:
msoc_clk  in  1  single clock
rst_int  in  1  synchronous active-high reset
rx_axis_tdata  in  8  received byte
rx_axis_tvalid  in  1  byte valid; no backpressure exists
rx_axis_tlast  in  1  last byte of frame
rx_axis_tuser  in  1  frame error, sampled with tlast
mac_address  in  48  station address
promiscuous  in  1  accept all destination addresses
irq_en  in  1  interrupt enable
mcast_hash  in  64  multicast hash table (used only with ETH_RX_MCAST_HASH_EN)
rd_en  in  1  buffer read strobe
rd_addr  in  PW+LW-4  {buffer, 64-bit word index}
rd_data  out  64  read data, valid one cycle after rd_en
len_sel  in  PW  buffer whose length is shown on len_data
len_data  out  LW  stored byte length of that buffer (combinational)
release_we  in  1  write strobe for firstbuf
release_ptr  in  PW  new firstbuf value
firstbuf  out  PW  oldest unreleased buffer
nextbuf  out  PW  buffer being filled or filled next
avail  out  1  nextbuf != firstbuf
full  out  1  (nextbuf+1) mod NBUF == firstbuf
drop_count  out  16  frames dropped, saturating
eth_irq  out  1  registered avail & irq_en

Behaviour:
- Reset values:
  - firstbuf, nextbuf, drop_count, eth_irq and rd_data are 0.
  - The FSM is IDLE.
  - The length table is not reset.
- FSM states: IDLE, RECV, DISCARD.
- IDLE, on the first valid byte:
  - full=1: go to DISCARD and mark the frame as a full-ring drop.
  - Otherwise go to RECV with byte count 0.
- RECV, for each valid byte:
  - Write the byte to lane count[2:0] of word {nextbuf, count[LW-2:3]} using byte enables.
  - Bytes 0..5 are shifted into dest_mac.
  - Increment count.
  - If count reaches BUF_BYTES without tlast, go to DISCARD and mark the frame oversize.
- On tlast in RECV, the total length is L = count+1.
  - Commit requires all of: tuser=0, L >= MIN_LEN, and an address match.
  - Address match = dest_mac all ones, OR dest_mac equals mac_address, OR dest_mac[47:24] = 01_00_5E, OR promiscuous. A tlast at byte index <6 is always a runt.
  - On commit, in the same cycle: len_table[nextbuf] <= L. In the next cycle nextbuf increments modulo NBUF. Then return to IDLE.
  - Without commit: return to IDLE; nextbuf and the length table are unchanged.
- DISCARD: ignore bytes until tlast, then return to IDLE. drop_count increments once at that tlast for full-ring and oversize drops only. A filter mismatch is not a drop.
- A frame that is not committed leaves only stale data in buffer nextbuf, which is harmless.
- Release: on release_we, firstbuf <= release_ptr.
  - A simultaneous commit and release both take effect.
  - full and avail are recomputed from the new registered values next cycle.
- The full check happens only at frame start. The in-flight buffer is never visible to the CPU, so a frame started while full=0 always completes.
- The read port is synchronous with 1-cycle latency. rd_data holds its value when rd_en=0. A read of the buffer being written returns the old or new byte; both are acceptable.
- drop_count saturates at 16'hFFFF.
- Reset mid-frame aborts the frame. The FSM then waits for the next tvalid rising from IDLE, and the remainder of the aborted frame is treated as a new frame.

Optional Feature:
ETH_RX_MCAST_HASH_EN
- Defined: the 01_00_5E prefix rule is replaced by a hash rule.
  - Group frames are those with dest_mac[40]=1 that are not broadcast.
  - They are accepted if mcast_hash[h] = 1.
  - h is the 6-bit XOR of the low six bits of the six destination bytes.
- Undefined: mcast_hash is ignored and the prefix rule applies.

Decomposition:
- Package eth_rx_pkg holds:
  - the FSM state enum (IDLE, RECV, DISCARD)
  - constants BCAST_MAC and IPV4_MCAST_PREFIX (24'h01005E)
  - the drop-cause enum
- One sub-module: eth_rx_ring_ram, a simple dual-port RAM with 64-bit words.
  - Port A: write with 8 byte enables.
  - Port B: synchronous read.
  - Depth NBUF*BUF_BYTES/8.

Test Plan:
- Broadcast frame of 64 bytes, ring empty -> nextbuf 0->1, len_data[0]=64, avail=1, eth_irq=1 one cycle later with irq_en=1, rd_addr 0 returns the first 8 bytes little-endian.
- Unicast frame to 02:07:89:00:01:23 with mac_address 48'h230100890702 and promiscuous=0 -> dropped silently: nextbuf unchanged, drop_count 0. Repeat with promiscuous=1 -> committed.
- NBUF=4: send 3 good frames -> full=1. Send a 4th -> drop_count=1, nextbuf=3. release_ptr=1 -> full=0. Send a 5th -> committed to buffer 3, nextbuf wraps to 0.
- 2049-byte frame with BUF_BYTES=2048 -> DISCARD, drop_count+1. A 10-byte runt and a 64-byte frame with tuser=1 -> not committed, drop_count unchanged.
- Release in the same cycle as a commit (firstbuf 0->2, nextbuf 2->3) -> both registers update, avail=1.
- With ETH_RX_MCAST_HASH_EN: 01:00:5E:00:00:FB with its hash bit set -> accepted; the same frame with the bit clear -> rejected.
